mopshub_bus_test_seq: RTL and testbench

MOPSHUB_BUS_TEST_SEQ -- requirements
Module: mopshub_bus_test_seq

---
 rtl/mopshub_bus_test_seq.sv | 157 +++++++++++++++
 tb/tb_mopshub_bus_test_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mopshub_bus_test_seq.sv
// Sequences RX/TX/ADV test phases across the CAN buses selected by bus_mask,
// recording a per-bus pass or timeout result for each run.
module mopshub_bus_test_seq #(
   parameter int N_BUSES     = 32,
   parameter int BUS_W       = 5,
   parameter int TIMEOUT_CYC = 4096,
   parameter int GAP_CYC     = 120
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [1:0]         mode,
   input  logic [N_BUSES-1:0] bus_mask,
   input  logic               phase_done,
   input  logic               phase_ok,
   output logic               test_rx,
   output logic               test_tx,
   output logic               test_adv,
   output logic [BUS_W-1:0]   bus_id,
   output logic               endwait_all,
   output logic               busy,
   output logic               done,
   output logic [N_BUSES-1:0] pass_mask,
   output logic [N_BUSES-1:0] timeout_mask
);

   typedef enum logic [3:0] {
      S_IDLE, S_SELECT, S_RX, S_ENDWAIT, S_GAP, S_TX, S_ADV, S_NEXT, S_FINISH
   } state_t;

   localparam int PCW = $clog2(TIMEOUT_CYC + 1);
   localparam int GCW = $clog2(GAP_CYC + 1);
   localparam logic [PCW-1:0]   PHASE_LAST = PCW'(TIMEOUT_CYC - 1);
   localparam logic [GCW-1:0]   GAP_LAST   = GCW'(GAP_CYC - 1);
   localparam logic [BUS_W-1:0] IDX_LAST   = BUS_W'(N_BUSES - 1);

   state_t             state_q, state_d;
   logic [1:0]         mode_q, mode_d;
   logic [N_BUSES-1:0] mask_q, mask_d;
   logic [N_BUSES-1:0] pass_q, pass_d;
   logic [N_BUSES-1:0] tmo_q, tmo_d;
   logic [BUS_W-1:0]   idx_q, idx_d;
   logic [PCW-1:0]     phase_cnt_q, phase_cnt_d;
   logic [GCW-1:0]     gap_cnt_q, gap_cnt_d;
   logic               ok_q, ok_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mode_q      <= '0;
         mask_q      <= '0;
         pass_q      <= '0;
         tmo_q       <= '0;
         idx_q       <= '0;
         phase_cnt_q <= '0;
         gap_cnt_q   <= '0;
         ok_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         mask_q      <= mask_d;
         pass_q      <= pass_d;
         tmo_q       <= tmo_d;
         idx_q       <= idx_d;
         phase_cnt_q <= phase_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         ok_q        <= ok_d;
      end
   end

   // Counters fall back to zero whenever they are not advancing, so every
   // phase and gap starts counting from a clean slate.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      mask_d      = mask_q;
      pass_d      = pass_q;
      tmo_d       = tmo_q;
      idx_d       = idx_q;
      ok_d        = ok_q;
      phase_cnt_d = '0;
      gap_cnt_d   = '0;

      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  mode_d  = mode;
                  mask_d  = bus_mask;
                  pass_d  = '0;
                  tmo_d   = '0;
                  idx_d   = '0;
                  state_d = S_SELECT;
               end
            end
            S_SELECT: begin
               if (mask_q[idx_q]) begin
                  ok_d    = 1'b1;
                  state_d = (mode_q == 2'b01) ? S_TX : S_RX;
               end else if (idx_q == IDX_LAST) begin
                  state_d = S_FINISH;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            S_RX, S_TX, S_ADV: begin
               // phase_done wins over a timeout landing in the same cycle
               if (phase_done) begin
                  ok_d = ok_q & phase_ok;
                  case (state_q)
                     S_RX:    state_d = mode_q[1] ? S_ENDWAIT : S_NEXT;
                     S_TX:    state_d = (mode_q == 2'b11) ? S_ADV : S_NEXT;
                     default: state_d = S_NEXT;
                  endcase
               end else if (phase_cnt_q == PHASE_LAST) begin
                  tmo_d[idx_q] = 1'b1;
                  ok_d         = 1'b0;
                  state_d      = S_NEXT;
               end else begin
                  phase_cnt_d = phase_cnt_q + 1'b1;
               end
            end
            S_ENDWAIT: state_d = S_GAP;
            S_GAP: begin
               if (gap_cnt_q == GAP_LAST) state_d = S_TX;
               else                       gap_cnt_d = gap_cnt_q + 1'b1;
            end
            S_NEXT: begin
               if (ok_q) pass_d[idx_q] = 1'b1;
               if (idx_q == IDX_LAST) begin
                  state_d = S_FINISH;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_SELECT;
               end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // Outputs decode the state register directly so reset clears them at once.
   assign test_rx      = (state_q == S_RX);
   assign test_tx      = (state_q == S_TX);
   assign test_adv     = (state_q == S_ADV);
   assign endwait_all  = (state_q == S_ENDWAIT);
   assign done         = (state_q == S_FINISH);
   assign busy         = (state_q != S_IDLE) && (state_q != S_FINISH);
   assign bus_id       = idx_q;
   assign pass_mask    = pass_q;
   assign timeout_mask = tmo_q;

endmodule

// File: tb/tb_mopshub_bus_test_seq.sv
// Directed bench for mopshub_bus_test_seq: table of full runs plus
// hand-written abort, reset and timeout-coincidence sequences.
module tb_mopshub_bus_test_seq;
   localparam int N         = 32;
   localparam int GAP       = 120;
   localparam int RUN_LIMIT = 20000;

   logic           clk = 1'b0;
   logic           rst, start, abort;
   logic [1:0]     mode;
   logic [N-1:0]   bus_mask;
   logic           phase_done, phase_ok;
   logic           test_rx, test_tx, test_adv, endwait_all, busy, done;
   logic [4:0]     bus_id;
   logic [N-1:0]   pass_mask, timeout_mask;

   mopshub_bus_test_seq dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
      .bus_mask(bus_mask), .phase_done(phase_done), .phase_ok(phase_ok),
      .test_rx(test_rx), .test_tx(test_tx), .test_adv(test_adv),
      .bus_id(bus_id), .endwait_all(endwait_all), .busy(busy), .done(done),
      .pass_mask(pass_mask), .timeout_mask(timeout_mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   mode;
      logic [N-1:0] mask;
      int           lat;
      logic [N-1:0] ok_mask;
      logic [N-1:0] silent;
      logic [N-1:0] exp_pass;
      logic [N-1:0] exp_tmo;
      int           exp_endwait;
      int           exp_starts;
      int           exp_first;
      int           exp_last;
      int           exp_last_len;
      int           exp_cycles;
      string        name;
   } vec_t;

   vec_t vecs[6];
   int   n_checks = 0;
   int   n_fail   = 0;

   logic         gen_en = 1'b0, gen_done = 1'b0, gen_ok = 1'b0;
   logic         man_done = 1'b0, man_ok = 1'b0;
   int           gen_lat = 1, gen_cnt = 0;
   logic [N-1:0] gen_ok_mask = '0, gen_silent = '0;

   assign phase_done = gen_done | man_done;
   assign phase_ok   = man_done ? man_ok : gen_ok;

   // Data-generator model: answers each phase after gen_lat cycles unless the bus is silent
   always @(negedge clk) begin
      gen_done = 1'b0;
      if (gen_en && (test_rx || test_tx || test_adv) && !gen_silent[bus_id]) begin
         if (gen_cnt >= gen_lat - 1) begin
            gen_done = 1'b1;
            gen_ok   = gen_ok_mask[bus_id];
            gen_cnt  = 0;
         end else begin
            gen_cnt++;
         end
      end else begin
         gen_cnt = 0;
      end
   end

   logic [2:0] cur = '0, prev = '0;
   int n_multi, n_endwait, n_done, n_starts, first_id, last_id, run, last_len;
   int gap_run, gap_good;
   bit in_gap;

   // Output monitor: pulse counts, phase lengths, bus order and gap length
   always @(negedge clk) begin
      cur = {test_adv, test_tx, test_rx};
      if (!$onehot0(cur)) n_multi++;
      if (endwait_all) n_endwait++;
      if (done) n_done++;
      if (prev != 3'b000 && cur != prev) last_len = run;
      if (cur != 3'b000 && cur != prev) begin
         if (n_starts == 0) first_id = int'(bus_id);
         last_id = int'(bus_id);
         n_starts++;
      end
      if (cur != 3'b000) run = (cur == prev) ? run + 1 : 1;
      else               run = 0;
      prev = cur;
      if (endwait_all) begin
         in_gap  = 1'b1;
         gap_run = 0;
      end else if (in_gap) begin
         if (test_tx) begin
            in_gap = 1'b0;
            if (gap_run == GAP) gap_good++;
         end else if (cur == 3'b000) begin
            gap_run++;
         end else begin
            in_gap = 1'b0;
         end
      end
   end

   task automatic reset_monitors();
      n_multi = 0; n_endwait = 0; n_done = 0; n_starts = 0;
      first_id = 0; last_id = 0; run = 0; last_len = 0;
      gap_run = 0; gap_good = 0; in_gap = 1'b0; prev = '0;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_for(input int sel, input int id, input int limit, output logic hit);
      hit = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (((sel == 0 && test_rx) || (sel == 1 && test_tx) ||
              (sel == 2 && endwait_all) || (sel == 3 && done)) &&
             (id < 0 || int'(bus_id) == id)) begin
            hit = 1'b1;
            return;
         end
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Full run from IDLE to done, then compare every recorded result
   task automatic applyStimulus(input vec_t v);
      int cycles;
      mode        = v.mode;
      bus_mask    = v.mask;
      gen_lat     = v.lat;
      gen_ok_mask = v.ok_mask;
      gen_silent  = v.silent;
      gen_en      = 1'b1;
      reset_monitors();
      pulse_start();
      checkOutput({v.name, "_busy_start"}, busy, 1);
      cycles = 1;
      while (!done && cycles < RUN_LIMIT) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput({v.name, "_done_seen"}, done, 1);
      if (v.exp_cycles != 0) checkOutput({v.name, "_latency"}, cycles, v.exp_cycles);
      @(negedge clk);
      @(negedge clk);
      checkOutput({v.name, "_busy_end"}, busy, 0);
      checkOutput({v.name, "_pass"}, pass_mask, v.exp_pass);
      checkOutput({v.name, "_timeout"}, timeout_mask, v.exp_tmo);
      checkOutput({v.name, "_endwait"}, n_endwait, v.exp_endwait);
      checkOutput({v.name, "_gaps"}, gap_good, v.exp_endwait);
      checkOutput({v.name, "_done_pulses"}, n_done, 1);
      checkOutput({v.name, "_multi_strobe"}, n_multi, 0);
      checkOutput({v.name, "_phases"}, n_starts, v.exp_starts);
      checkOutput({v.name, "_first_id"}, first_id, v.exp_first);
      checkOutput({v.name, "_last_id"}, last_id, v.exp_last);
      checkOutput({v.name, "_last_len"}, last_len, v.exp_last_len);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic hit;
      vecs[0] = '{2'b10, 32'hFFFF_FFFF, 50, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0,
                  32, 64, 0, 31, 50, 0, "rxtx_all"};
      vecs[1] = '{2'b00, 32'h0000_0005, 10, 32'hFFFF_FFFF, 32'h0000_0004, 32'h1, 32'h4,
                  0, 2, 0, 2, 4096, 0, "rx_timeout"};
      vecs[2] = '{2'b11, 32'h0, 5, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0,
                  0, 0, 0, 0, 0, 33, "empty_mask"};
      vecs[3] = '{2'b11, 32'h0000_000F, 5, 32'hFFFF_FFFD, 32'h0, 32'hD, 32'h0,
                  4, 12, 0, 3, 5, 0, "adv_okmask"};
      vecs[4] = '{2'b01, 32'h0000_00F0, 1, 32'hFFFF_FFFF, 32'h0, 32'hF0, 32'h0,
                  0, 4, 4, 7, 1, 0, "tx_only"};
      vecs[5] = '{2'b00, 32'h0000_0001, 3, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0,
                  0, 1, 0, 0, 3, 0, "after_reset"};

      rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00; bus_mask = '0;
      reset_monitors();
      repeat (3) @(negedge clk);
      checkOutput("reset_flags", {test_rx, test_tx, test_adv, endwait_all, busy, done}, 0);
      checkOutput("reset_bus_id", bus_id, 0);
      checkOutput("reset_pass", pass_mask, 0);
      checkOutput("reset_timeout", timeout_mask, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

      // phase_done lands exactly on the timeout cycle of bus 3's RX phase
      @(negedge clk);
      gen_en = 1'b0; mode = 2'b11; bus_mask = 32'h8;
      reset_monitors();
      pulse_start();
      wait_for(0, 3, 200, hit);
      checkOutput("coinc_rx_reached", hit, 1);
      for (int i = 1; i < 4096; i++) @(negedge clk);
      checkOutput("coinc_rx_held", test_rx, 1);
      man_done = 1'b1; man_ok = 1'b1;
      @(negedge clk);
      man_done = 1'b0; man_ok = 1'b0;
      checkOutput("coinc_rx_ended", test_rx, 0);
      checkOutput("coinc_endwait", endwait_all, 1);
      gen_lat = 2; gen_ok_mask = '1; gen_silent = '0; gen_en = 1'b1;
      wait_for(3, -1, 1000, hit);
      checkOutput("coinc_done", hit, 1);
      @(negedge clk);
      @(negedge clk);
      checkOutput("coinc_timeout", timeout_mask, 0);
      checkOutput("coinc_pass", pass_mask, 32'h8);
      checkOutput("coinc_phases", n_starts, 3);

      // ignored start mid-run, then abort during TX of bus 5
      mode = 2'b01; bus_mask = '1; gen_lat = 4; gen_ok_mask = '1; gen_silent = '0;
      reset_monitors();
      pulse_start();
      wait_for(1, 3, 500, hit);
      checkOutput("abort_tx3_reached", hit, 1);
      pulse_start();
      checkOutput("start_ignored_id", bus_id, 3);
      wait_for(1, 5, 500, hit);
      checkOutput("abort_tx5_reached", hit, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort_tx_low", test_tx, 0);
      checkOutput("abort_busy_low", busy, 0);
      checkOutput("abort_pass_kept", pass_mask, 32'h1F);
      repeat (3) @(negedge clk);
      checkOutput("abort_no_done", n_done, 0);
      checkOutput("abort_stays_idle", {test_rx, test_tx, test_adv}, 0);
      mode = 2'b00; bus_mask = 32'h1; gen_lat = 3;
      pulse_start();
      checkOutput("restart_clears_pass", pass_mask, 0);
      checkOutput("restart_busy", busy, 1);
      wait_for(3, -1, 500, hit);
      checkOutput("restart_done", hit, 1);
      @(negedge clk);
      checkOutput("restart_pass", pass_mask, 32'h1);

      // asynchronous reset in the middle of bus 1's gap
      mode = 2'b10; bus_mask = 32'h3; gen_lat = 3;
      reset_monitors();
      pulse_start();
      wait_for(2, 1, 600, hit);
      checkOutput("gap_reached", hit, 1);
      repeat (10) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("rst_async_flags", {test_rx, test_tx, test_adv, endwait_all, busy, done}, 0);
      checkOutput("rst_async_bus_id", bus_id, 0);
      checkOutput("rst_async_pass", pass_mask, 0);
      checkOutput("rst_async_timeout", timeout_mask, 0);
      @(negedge clk);
      rst = 1'b0;
      reset_monitors();
      repeat (3) @(negedge clk);
      checkOutput("rst_no_done", n_done, 0);
      applyStimulus(vecs[5]);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end
endmodule
